// File: rtl/up_down_sched_pkg.sv
// Shared types and constants for the up/down spike scheduler.
package up_down_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, REFRACT} sched_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any_req
);

  always_comb begin
    int idx;
    idx        = 0;
    winner_idx = '0;
    any_req    = |req;
    // Scan from the farthest offset back so the nearest request after the pointer wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(pointer) + k) % N;
      if (req[idx]) winner_idx = IW'(idx);
    end
    winner = any_req ? (N'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/up_down_sched.sv
// Round-robin spike scheduler driving a shared up/down counter, with shadow level,
// threshold fire and refractory hold. Define UP_DOWN_SCHED_LEAK_EN for the idle leak timer.
module up_down_sched
  import up_down_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 8,
  parameter int THRESH      = 200,
  parameter int REFRACT_CYC = 3,
  parameter int LEAK_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_dir,
  output logic [N_REQ-1:0] grant,
  output logic             state,
  output logic             step,
  output logic [CNT_W-1:0] level,
  output logic             fire,
  output logic             busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
  localparam logic [CNT_W-1:0] LVL_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("up_down_sched: N_REQ must be 2..16");
  end
  if (THRESH < 1 || THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
    $error("up_down_sched: THRESH out of range");
  end
  if (LEAK_PERIOD < 1) begin : g_bad_leak
    $error("up_down_sched: LEAK_PERIOD must be positive");
  end

  sched_state_t     cur, nxt;
  logic [IW-1:0]    ptr, ptr_nxt, win_idx;
  logic [N_REQ-1:0] win, grant_nxt;
  logic             any_req, step_nxt, state_nxt, fire_nxt, leak_go;
  logic [CNT_W-1:0] level_nxt, up_lvl;
  logic [RW-1:0]    rcnt, rcnt_nxt;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req       (req),
    .pointer   (ptr),
    .winner    (win),
    .winner_idx(win_idx),
    .any_req   (any_req)
  );

`ifdef UP_DOWN_SCHED_LEAK_EN
  localparam int LW = $clog2(LEAK_PERIOD + 1);
  logic [LW-1:0] leak_cnt, leak_nxt;

  // Only uninterrupted idle cycles with charge on the level count toward a leak.
  always_comb begin
    leak_go  = 1'b0;
    leak_nxt = '0;
    if (cur == IDLE && !any_req && level != '0) begin
      if (leak_cnt == LW'(LEAK_PERIOD - 1)) leak_go = 1'b1;
      else                                  leak_nxt = leak_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) leak_cnt <= '0;
    else     leak_cnt <= leak_nxt;
`else
  assign leak_go = 1'b0;
`endif

  always_comb begin
    nxt       = cur;
    ptr_nxt   = ptr;
    grant_nxt = '0;
    step_nxt  = 1'b0;
    state_nxt = state;
    fire_nxt  = 1'b0;
    level_nxt = level;
    rcnt_nxt  = rcnt;
    up_lvl    = (level == LVL_MAX) ? level : level + 1'b1;
    case (cur)
      IDLE: begin
        if (any_req) begin
          grant_nxt = win;
          step_nxt  = 1'b1;
          state_nxt = req_dir[win_idx];
          ptr_nxt   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          nxt       = ISSUE;
        end else if (leak_go) begin
          step_nxt  = 1'b1;
          state_nxt = DIR_DOWN;
          nxt       = ISSUE;
        end
      end
      ISSUE: begin
        nxt = IDLE;
        if (state == DIR_UP) begin
          if (up_lvl >= THR) begin
            fire_nxt  = 1'b1;
            level_nxt = '0;
            if (REFRACT_CYC > 0) begin
              nxt      = REFRACT;
              rcnt_nxt = RW'(REFRACT_CYC - 1);
            end
          end else begin
            level_nxt = up_lvl;
          end
        end else begin
          // The counter still gets a down step at zero; only the shadow clamps.
          level_nxt = (level == '0) ? level : level - 1'b1;
        end
      end
      REFRACT: begin
        if (rcnt == '0) nxt = IDLE;
        else            rcnt_nxt = rcnt - 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= IDLE;
      ptr   <= '0;
      grant <= '0;
      step  <= 1'b0;
      state <= 1'b0;
      fire  <= 1'b0;
      level <= '0;
      rcnt  <= '0;
    end else begin
      cur   <= nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      step  <= step_nxt;
      state <= state_nxt;
      fire  <= fire_nxt;
      level <= level_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  assign busy = (cur != IDLE);

endmodule

// File: tb/tb_up_down_sched.sv
// Directed self-checking bench for up_down_sched (N_REQ=4, THRESH=3, REFRACT_CYC=3, LEAK_PERIOD=4).
module tb_up_down_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_dir, grant;
  logic       state, step, fire, busy;
  logic [7:0] level;
  int         n_chk = 0;
  int         n_fail = 0;

  // Observation word: {grant, step, state, fire, busy, level}
  wire [15:0] outs = {grant, step, state, fire, busy, level};

  always #5 clk = ~clk;

  up_down_sched #(
    .N_REQ(4), .CNT_W(8), .THRESH(3), .REFRACT_CYC(3), .LEAK_PERIOD(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .grant(grant),
    .state(state), .step(step), .level(level), .fire(fire), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = '0; req_dir = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_async: got %h want %h", outs, 16'h0); end
    tick(); tick();
    rst = 1'b0;
    n_chk++;
    if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_hold: got %h want %h", outs, 16'h0); end
  endtask

  task automatic test_single_up();
    req = 4'b0001; req_dir = 4'b0001;
    tick();
    n_chk++;
    if (outs !== {4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL single_grant: got %h want %h", outs, {4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
    end
    tick();
    req = '0;
    n_chk++;
    if (outs !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL single_level: got %h want %h", outs, {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1});
    end
    tick();
    n_chk++;
    if (outs !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL single_idle: got %h want %h", outs, {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [3];
    logic       es [3];
    logic [7:0] el [3];
    logic [7:0] prev_l;
    eg = '{4'b0001, 4'b0010, 4'b1000};
    es = '{1'b0, 1'b1, 1'b0};
    el = '{8'd0, 8'd1, 8'd0};
    prev_l = 8'd0;
    req = 4'b1011; req_dir = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (outs !== {eg[i], 1'b1, es[i], 1'b0, 1'b1, prev_l}) begin
        n_fail++; $display("FAIL rr_grant%0d: got %h want %h", i, outs, {eg[i], 1'b1, es[i], 1'b0, 1'b1, prev_l});
      end
      tick();
      req = req & ~eg[i];
      n_chk++;
      if (outs !== {4'b0000, 1'b0, es[i], 1'b0, 1'b0, el[i]}) begin
        n_fail++; $display("FAIL rr_idle%0d: got %h want %h", i, outs, {4'b0000, 1'b0, es[i], 1'b0, 1'b0, el[i]});
      end
      prev_l = el[i];
    end
    // Pointer wrapped to 0: index 0 beats index 3.
    req = 4'b1001; req_dir = 4'b0000;
    tick();
    n_chk++;
    if (outs !== {4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL rr_wrap: got %h want %h", outs, {4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    end
    tick();
    req = '0;
    n_chk++;
    if (outs !== 16'h0) begin n_fail++; $display("FAIL rr_down_at_zero: got %h want %h", outs, 16'h0); end
  endtask

  task automatic test_fire_refract();
    int busy_cyc;
    logic [15:0] e;
    busy_cyc = 0;
    req = 4'b0001; req_dir = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (outs !== {4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'(i)}) begin
        n_fail++; $display("FAIL fire_grant%0d: got %h want %h", i, outs, {4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'(i)});
      end
      tick();
      n_chk++;
      if (outs !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1)}) begin
        n_fail++; $display("FAIL fire_level%0d: got %h want %h", i, outs, {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1)});
      end
    end
    tick();
    if (busy) busy_cyc++;
    n_chk++;
    if (outs !== {4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2}) begin
      n_fail++; $display("FAIL fire_grant2: got %h want %h", outs, {4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2});
    end
    // Three refractory cycles (fire only in the first), then idle, then the held request.
    req = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy) busy_cyc++;
      if (c == 0) begin req = 4'b0100; req_dir = 4'b0000; end
      case (c)
        0:       e = {4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
        1, 2:    e = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        3:       e = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        default: e = {4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
      endcase
      if (c == 4) busy_cyc--;
      n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL refract_c%0d: got %h want %h", c, outs, e); end
    end
    n_chk++;
    if (busy_cyc != 4) begin n_fail++; $display("FAIL busy_len: got %0d want %0d", busy_cyc, 4); end
    tick();
    req = '0;
    n_chk++;
    if (outs !== 16'h0) begin n_fail++; $display("FAIL refract_after: got %h want %h", outs, 16'h0); end
  endtask

  task automatic test_reset_refract();
    req = 4'b0010; req_dir = 4'b0010;
    for (int i = 0; i < 3; i++) begin tick(); tick(); end
    req = '0;
    n_chk++;
    if (outs !== {4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL rr_pre_fire: got %h want %h", outs, {4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0});
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_mid_refract: got %h want %h", outs, 16'h0); end
    tick();
    rst = 1'b0;
    req = 4'b1001; req_dir = 4'b1000;
    tick();
    n_chk++;
    if (outs !== {4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL post_reset_prio: got %h want %h", outs, {4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    end
    tick();
    req = '0;
    n_chk++;
    if (outs !== 16'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", outs, 16'h0); end
  endtask

  task automatic test_leak();
    int nstep;
    logic [15:0] e;
    nstep = 0;
    req = 4'b0001; req_dir = 4'b0001;
    tick(); tick(); tick(); tick();
    req = '0;
    n_chk++;
    if (outs !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL leak_setup: got %h want %h", outs, {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    end
`ifdef UP_DOWN_SCHED_LEAK_EN
    for (int c = 1; c <= 10; c++) begin
      tick();
      case (c)
        1, 2, 3:    e = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        4:          e = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        5, 6, 7, 8: e = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        9:          e = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        default:    e = 16'h0;
      endcase
      n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL leak_c%0d: got %h want %h", c, outs, e); end
    end
    for (int c = 0; c < 8; c++) begin tick(); if (step) nstep++; end
    n_chk++;
    if (nstep != 0 || level !== 8'd0) begin
      n_fail++; $display("FAIL leak_stop: got steps=%0d level=%0d want steps=0 level=0", nstep, level);
    end
    // Request lands on the cycle the leak would have fired.
    req = 4'b0001; req_dir = 4'b0001;
    tick(); tick();
    req = '0;
    tick(); tick(); tick();
    req = 4'b0010; req_dir = 4'b0010;
    tick();
    n_chk++;
    if (outs !== {4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL leak_req_wins: got %h want %h", outs, {4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1});
    end
    tick();
    req = '0;
    n_chk++;
    if (outs !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL leak_req_level: got %h want %h", outs, {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    end
`else
    for (int c = 0; c < 12; c++) begin tick(); if (step) nstep++; end
    n_chk++;
    if (nstep != 0 || level !== 8'd2) begin
      n_fail++; $display("FAIL no_leak: got steps=%0d level=%0d want steps=0 level=2", nstep, level);
    end
`endif
  endtask

  initial begin
    rst = 1'b0; req = '0; req_dir = '0;
    test_reset();
    test_single_up();
    test_reset();
    test_round_robin();
    test_reset();
    test_fire_refract();
    test_reset_refract();
    test_reset();
    test_leak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down_sched.md
Name: up_down_sched

Overview:
- Scheduler that shares one up/down counter datapath (driven by its `state` direction input) between N spike requesters.
- Each requester posts an up (excitatory) or down (inhibitory) event.
- The block grants requests round-robin and issues one direction/step command per grant.
- It keeps a shadow level of the counter, fires when the level crosses a threshold, then enforces a refractory period. It sits between the spike sources and the up/down counter in a neuron tile.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- CNT_W, 8, width of the shadow level.
- THRESH, 200, level at which `fire` is produced (1..2^CNT_W-1).
- REFRACT_CYC, 3, cycles grants are blocked after a fire (0 allowed).
- LEAK_PERIOD, 16, idle cycles between leak steps (used only with LEAK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester event request; held until granted.
- req_dir  in  N_REQ  per-requester direction, 1 = up, 0 = down; valid while req is high.
- grant  out  N_REQ  one-hot, one-cycle grant pulse.
- state  out  1  direction to the up/down counter; holds its last value between steps.
- step  out  1  one-cycle strobe; the counter moves by one in direction `state`.
- level  out  CNT_W  shadow level.
- fire  out  1  one-cycle spike pulse.
- busy  out  1  high in the ISSUE and REFRACT states.

Behaviour:
- Reset values: grant=0, state=0, step=0, level=0, fire=0, busy=0, FSM=IDLE, round-robin pointer=0 (index 0 has highest priority). Reset is honoured in any state, including mid-REFRACT; level clears.
- FSM states: IDLE, ISSUE, REFRACT.
- IDLE:
  - If any req is high, the arbiter picks the winner: the first set req at or after pointer, wrapping modulo N_REQ.
  - At the next edge: grant[w]=1, step=1, state=req_dir[w], go to ISSUE, pointer=w+1 mod N_REQ.
  - No req: stay in IDLE, no outputs.
- ISSUE (exactly 1 cycle):
  - grant and step are visible for this cycle. req is ignored during ISSUE.
  - At the edge ending ISSUE: level updates, and grant and step drop.
    - Up: level=min(level+1, 2^CNT_W-1).
    - Down: level=max(level-1, 0). A down step at level 0 is still issued to the counter; level stays 0.
  - If up and the new level >= THRESH: fire=1 for the next cycle, level=0. Go to REFRACT if REFRACT_CYC>0, else IDLE.
  - Otherwise go to IDLE.
- Requester handshake: the requester samples grant at the edge ending ISSUE and drops or changes req from the next cycle. Maximum throughput is one grant per 2 cycles.
- REFRACT:
  - Down-counts REFRACT_CYC cycles. No grants; pending req stay pending.
  - Goes to IDLE after the last cycle.
  - fire is asserted in the first REFRACT cycle.
- Latency: req high in IDLE at cycle k gives grant/step in cycle k+1 and the level update visible in cycle k+2.
- At most one grant bit is ever set. Grant is never asserted for a requester whose req is low.

Optional Feature:
- Macro: `UP_DOWN_SCHED_LEAK_EN`.
- Defined:
  - A leak timer counts consecutive IDLE cycles with no req and level>0.
  - At LEAK_PERIOD it issues step=1, state=0 with no grant. The step takes the ISSUE path; the level decrements.
  - The timer resets on any grant, leak step, or entry to REFRACT.
  - A req always has priority over a leak in the same cycle.
- Undefined: no timer logic exists; the level changes only via granted requests.

Decomposition:
- Package up_down_sched_pkg:
  - FSM state enum sched_state_t {IDLE, ISSUE, REFRACT}.
  - Localparams DIR_UP=1'b1 and DIR_DOWN=1'b0.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, pointer.
  - Outputs: one-hot winner, winner index, any_req.
  - Purely combinational.
- The FSM, level, refractory counter and leak timer live in up_down_sched.

Test Plan:
- Reset, then req=4'b0001, req_dir[0]=1 → grant=0001, step=1, state=1 one cycle later; level=1 one cycle after that.
- req=4'b1011 held, all requesters drop req after grant → grants are issued in the order 0001, 0010, 1000, with one grant every 2 cycles. The pointer wraps back to index 0.
- THRESH=3, REFRACT_CYC=3, three up grants → fire pulses once, level=0, busy is high for 4 cycles (ISSUE + 3 REFRACT). A req asserted during REFRACT is granted in the first cycle after REFRACT ends.
- Level=0, down request → step=1, state=0 issued; level stays 0. Level=255 (CNT_W=8, THRESH=255 disabled scenario uses THRESH=255 with a preset path) with an up request → level saturates, no wrap to 0.
- rst asserted in the second REFRACT cycle → all outputs 0 immediately (asynchronously); a req after release is granted with priority to index 0.
- With `UP_DOWN_SCHED_LEAK_EN`, LEAK_PERIOD=4, level=2, no req → step with state=0 every 5 cycles; level goes 2→1→0, then no more steps. A req arriving on the leak cycle wins.
